// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with a fixed request-to-response latency.
// Define DATA_MEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // a raised valid and its payload stay put until that edge.

  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] WORDS_LIMIT = 30'(MEM_WORDS);
  localparam logic [3:0]  LAT_M1      = 4'(LATENCY - 1);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] rd_word_q;

  logic          accept;
  logic          op_known;
  logic          is_nop;
  logic          is_store;
  logic          misaligned;
  logic          out_of_range;
  logic          req_fault;
  logic [1:0]    eff_off;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] widx;

  assign widx = req_addr[AW+1:2];

  // Request decode: everything here is evaluated in the accept cycle only.
  always_comb begin
    op_known = 1'b0;
    case (req_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_NOP: op_known = 1'b1;
      default:                     op_known = 1'b0;
    endcase
    is_nop       = (req_op == OP_NOP);
    is_store     = req_op[3] & ~is_nop;
    misaligned   = ((req_op[1:0] == 2'b01) & req_addr[0]) |
                   ((req_op[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= WORDS_LIMIT);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    req_fault = ~op_known | out_of_range | misaligned;
    eff_off   = req_addr[1:0];
`else
    req_fault = ~op_known | out_of_range;
    case (req_op[1:0])
      2'b01:   eff_off = {req_addr[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = req_addr[1:0];
    endcase
`endif
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_word = req_data;
    case (req_op[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << eff_off;
        wr_word = {4{req_data[7:0]}};
      end
      2'b01: begin
        wr_be   = eff_off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_data[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_word = req_data;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_word = req_data;
      end
    endcase
  end

  assign accept = req_valid & req_ready;
  assign wr_en  = accept & is_store & ~req_fault;
  assign rd_en  = accept & ~is_nop & ~is_store;

  // Array has no reset; the read word is captured at the accept edge alongside the request.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[widx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    if (rd_en) rd_word_q <= mem[widx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      off_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    off_d     = off_q;
    err_d     = err_q;
    req_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !is_nop) begin
          op_d    = req_op;
          off_d   = eff_off;
          err_d   = req_fault;
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Load formatting works from the registered op/offset so the response stays stable in RESP.
  always_comb begin
    case (off_q)
      2'd0:    sel_byte = rd_word_q[7:0];
      2'd1:    sel_byte = rd_word_q[15:8];
      2'd2:    sel_byte = rd_word_q[23:16];
      default: sel_byte = rd_word_q[31:24];
    endcase
    sel_half  = off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    rsp_valid = (state_q == S_RESP);
    rsp_err   = rsp_valid & err_q;
    rsp_data  = 32'd0;
    if (rsp_valid && !err_q) begin
      case (op_q)
        OP_LB:   rsp_data = {{24{sel_byte[7]}}, sel_byte};
        OP_LH:   rsp_data = {{16{sel_half[15]}}, sel_half};
        OP_LW:   rsp_data = rd_word_q;
        OP_LBU:  rsp_data = {24'd0, sel_byte};
        OP_LHU:  rsp_data = {16'd0, sel_half};
        default: rsp_data = 32'd0;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: two instances (LATENCY 1 and 3) against a byte-level memory model.
module tb_data_mem_responder;

  localparam int MW   = 256;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  localparam logic [3:0] LB = 4'b0000, LH = 4'b0001, LW = 4'b0010, LBU = 4'b0100,
                         LHU = 4'b0101, SB = 4'b1000, SH = 4'b1001, SW = 4'b1010,
                         NOP = 4'b1111;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [3:0]  req_op    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic [1:0]  dbg_state [2];

  logic [31:0] mm [2][MW];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_op(req_op[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
  );

  data_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_op(req_op[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: access size from the op, fault rules, byte-lane update and extension by arithmetic.
  function automatic void model(input int s, input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] ed, output logic ee);
    int unsigned widx;
    int          boff;
    int          sz;
    longint      v;
    ed   = 32'd0;
    ee   = 1'b0;
    widx = addr >> 2;
    boff = int'(addr % 4);
    case (op)
      LB, LBU, SB: sz = 1;
      LH, LHU, SH: sz = 2;
      LW, SW:      sz = 4;
      default: begin
        ee = 1'b1;
        return;
      end
    endcase
    if (widx >= MW) begin
      ee = 1'b1;
      return;
    end
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if (boff % sz != 0) begin
      ee = 1'b1;
      return;
    end
`else
    boff = boff - (boff % sz);
`endif
    if (op[3]) begin
      for (int i = 0; i < sz; i++) mm[s][widx][8*(boff+i) +: 8] = data[8*i +: 8];
      return;
    end
    v = longint'(mm[s][widx] >> (8*boff)) & ((longint'(1) << (8*sz)) - 1);
    if (!op[2] && sz < 4 && v >= (longint'(1) << (8*sz - 1))) v = v - (longint'(1) << (8*sz));
    ed = v[31:0];
  endfunction

  task automatic do_req(input int s, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input int hold,
                        output logic [31:0] got_d, output logic got_e);
    logic [31:0] ed;
    logic        ee;
    int          k;
    int          lat;
    lat   = (s == 0) ? LAT0 : LAT1;
    got_d = 32'd0;
    got_e = 1'b0;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready[s]), 32'd1);
    req_valid[s] = 1'b1;
    req_op[s]    = op;
    req_addr[s]  = addr;
    req_data[s]  = data;
    @(posedge clk);
    #1;
    req_valid[s] = 1'b0;
    req_addr[s]  = $urandom;
    req_data[s]  = $urandom;
    req_op[s]    = 4'($urandom_range(0, 15));
    if (op == NOP) begin
      for (int i = 0; i < lat + 2; i++) begin
        @(negedge clk);
        check("nop_no_rsp", 32'(rsp_valid[s]), 32'd0);
        check("nop_ready", 32'(req_ready[s]), 32'd1);
      end
      return;
    end
    model(s, op, addr, data, ed, ee);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!rsp_valid[s]) check("busy_ready", 32'(req_ready[s]), 32'd0);
    end while (!rsp_valid[s] && k < 40);
    check("rsp_latency", 32'(k), 32'(lat));
    if (!rsp_valid[s]) return;
    got_d = rsp_data[s];
    got_e = rsp_err[s];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[s]), 32'd1);
      check("hold_data", rsp_data[s], got_d);
      check("hold_err", 32'(rsp_err[s]), 32'(got_e));
      check("hold_ready", 32'(req_ready[s]), 32'd0);
    end
    check("rsp_data", rsp_data[s], ed);
    check("rsp_err", 32'(rsp_err[s]), 32'(ee));
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[s] = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(rsp_valid[s]), 32'd0);
    check("post_ready", 32'(req_ready[s]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [3:0]  op_tab [12];
    int          s, w;
    logic [31:0] a;
    op_tab = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NOP, 4'b0011, 4'b0110, 4'b1011};
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'd0;
      req_data[i]  = 32'd0;
      req_op[i]    = NOP;
      rsp_ready[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_data", rsp_data[i], 32'd0);
      check("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    check("rst_req_ready0", 32'(req_ready[0]), 32'd1);
    check("rst_req_ready1", 32'(req_ready[1]), 32'd1);

    // Preload so every later load has a defined expectation.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < MW; j++) do_req(i, SW, 32'(j * 4), $urandom, 0, d, e);

    do_req(0, SW, 32'h10, 32'hDEADBEEF, 0, d, e);
    check("sw_data_zero", d, 32'd0);
    do_req(0, LW, 32'h10, 32'd0, 0, d, e);
    check("lw_deadbeef", d, 32'hDEADBEEF);
    check("lw_err", 32'(e), 32'd0);
    do_req(0, LB, 32'h13, 32'd0, 0, d, e);
    check("lb_13", d, 32'hFFFFFFDE);
    do_req(0, LBU, 32'h13, 32'd0, 0, d, e);
    check("lbu_13", d, 32'h000000DE);
    do_req(0, LH, 32'h10, 32'd0, 0, d, e);
    check("lh_10", d, 32'hFFFFBEEF);
    do_req(0, LHU, 32'h12, 32'd0, 0, d, e);
    check("lhu_12", d, 32'h0000DEAD);
    do_req(0, SB, 32'h11, 32'h55, 0, d, e);
    do_req(0, LW, 32'h10, 32'd0, 0, d, e);
    check("sb_merge", d, 32'hDEAD55EF);
    do_req(0, LW, 32'(MW * 4), 32'd0, 0, d, e);
    check("oor_err", 32'(e), 32'd1);
    check("oor_data", d, 32'd0);
    do_req(0, 4'b0011, 32'h10, 32'd0, 0, d, e);
    check("badop_err", 32'(e), 32'd1);
    do_req(0, SW, 32'h12, 32'hCAFEF00D, 0, d, e);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    check("sw_mis_err", 32'(e), 32'd1);
    do_req(0, LW, 32'h10, 32'd0, 0, d, e);
    check("sw_mis_nowrite", d, 32'hDEAD55EF);
`else
    check("sw_mis_err", 32'(e), 32'd0);
    do_req(0, LW, 32'h10, 32'd0, 0, d, e);
    check("sw_mis_aligned", d, 32'hCAFEF00D);
`endif
    do_req(0, NOP, 32'h10, 32'd0, 0, d, e);
    do_req(1, NOP, 32'h10, 32'd0, 0, d, e);

    do_req(1, SW, 32'h20, 32'h0BADF00D, 0, d, e);
    do_req(1, LW, 32'h20, 32'd0, 5, d, e);
    check("lat3_hold_lw", d, 32'h0BADF00D);

    // Reset with instance 0 in RESP and instance 1 in WAIT.
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = LW; req_addr[0] = 32'h20;
    req_valid[1] = 1'b1; req_op[1] = LW; req_addr[1] = 32'h20;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("pre_rst_resp0", 32'(rsp_valid[0]), 32'd1);
    check("pre_rst_wait1", 32'(rsp_valid[1]), 32'd0);
    resetn = 1'b0;
    #1;
    check("rst_async_valid0", 32'(rsp_valid[0]), 32'd0);
    check("rst_async_data0", rsp_data[0], 32'd0);
    check("rst_async_valid1", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_rsp0", 32'(rsp_valid[0]), 32'd0);
      check("rst_no_rsp1", 32'(rsp_valid[1]), 32'd0);
      check("rst_ready0", 32'(req_ready[0]), 32'd1);
      check("rst_ready1", 32'(req_ready[1]), 32'd1);
    end
    do_req(1, LW, 32'h20, 32'd0, 0, d, e);
    check("mem_kept_rst", d, 32'h0BADF00D);

    for (int n = 0; n < 200; n++) begin
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) w = MW + $urandom_range(0, 3);
      else w = $urandom_range(0, MW - 1);
      a = 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = a | 32'h8000_0000;
      do_req(s, op_tab[$urandom_range(0, 11)], a, $urandom, $urandom_range(0, 3), d, e);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096: number of 32-bit words in the internal data array (power of two).
REQ-002 SHALL have parameter LATENCY, default 1: cycles from request accept to rsp_valid assertion (range 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset, as below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  initiator presents a memory request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_op  input  4  mem op: LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010, NOP 1111.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 rsp_data  output  32  load result, extended per op; 0 for stores and errors.
REQ-014 rsp_err  output  1  request faulted; no memory side effect.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; on accept, op/addr/data SHALL be registered; later changes on req_* are ignored.
REQ-017 Accepted NOP SHALL be dropped: FSM stays IDLE, no response.
REQ-018 Accepted non-NOP SHALL enter WAIT with counter = LATENCY-1; RESP entered when counter reaches 0 (LATENCY=1: RESP on the edge after accept).
REQ-019 In RESP, rsp_valid = 1 and rsp_data/rsp_err SHALL be held stable until rsp_valid & rsp_ready, then return to IDLE on that edge.
REQ-020 Single outstanding request; max throughput is one request per LATENCY+1 cycles.
REQ-021 Stores SHALL write the array at the accept edge using byte enables: SB one byte at addr[1:0], SH two bytes at addr[1], SW all four; remaining bytes unchanged.
REQ-022 Loads SHALL read the word at addr[31:2]; LB/LH sign-extend, LBU/LHU zero-extend the selected byte/half; LW returns the word unmodified.
REQ-023 A load accepted immediately after a store response to the same word SHALL return the stored data.
REQ-024 Word index addr[31:2] >= MEM_WORDS SHALL give rsp_err = 1, rsp_data = 0, no write.
REQ-025 req_op values not listed in REQ-010 SHALL give rsp_err = 1, rsp_data = 0, no write.
REQ-026 Store responses SHALL return rsp_data = 0, rsp_err = 0.

Reset
REQ-027 On resetn low: FSM = IDLE, counter = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, req_ready = 1 after reset release.
REQ-028 Reset mid-operation SHALL discard any pending response; an accepted store already written SHALL NOT be undone.
REQ-029 The data array SHALL NOT be reset; contents are undefined until written.

Configuration
REQ-030 Macro DATA_MEM_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, SHALL give rsp_err = 1, rsp_data = 0, no write.
REQ-031 Macro undefined: offending low address bits SHALL be forced to zero (half to addr[1], word to addr[1:0] = 0) and the access completes without error.

Verification
REQ-032 LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid on edge after each accept, load rsp_data = 0xDEADBEEF, rsp_err = 0.
REQ-033 After REQ-032: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-034 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
REQ-035 LATENCY=3, rsp_ready held low 5 cycles: rsp_valid rises 3 cycles after accept, data stable, req_ready = 0 until the cycle after the rsp handshake.
REQ-036 LW at word index MEM_WORDS -> rsp_err = 1, rsp_data = 0; with DATA_MEM_MISALIGN_CHECK_EN, SW 0x12 -> rsp_err = 1 and word 0x10 unchanged; without it, SW 0x12 writes word 0x10.
REQ-037 resetn pulsed low while in WAIT -> rsp_valid = 0 immediately, no response after release, req_ready = 1.
